wb_interconnect_rr_nxm: RTL
===========================

WB_INTERCONNECT_RR_NXM -- requirements
Module: wb_interconnect_rr_nxm

Interface
REQ-001 Parameter N_MASTERS, default 2, number of masters (1..8), SHALL be supported.
REQ-002 Parameter N_SLAVES, default 7, number of slaves (1..16), SHALL be supported.
REQ-003 Parameter WB_ADDR_WIDTH, default 32, address width, SHALL be supported.
REQ-004 Parameter WB_DATA_WIDTH, default 32, data width (multiple of 8), SHALL be supported.
REQ-005 Parameter ADDR_RANGES, default all-zero, 2*N_SLAVES*WB_ADDR_WIDTH bits, SHALL hold {base,limit} pairs, slave 0 pair in the MSBs, base above limit, inclusive.
REQ-006 Parameter TIMEOUT_CYCLES, default 255, 0 = watchdog disabled, SHALL be supported.
REQ-007 Ports (one clock; reset asynchronous, active-low):
  clk  in  1  clock
  rstn  in  1  asynchronous active-low reset
  m_adr/m_dat_w/m_sel/m_cti/m_bte/m_cyc/m_stb/m_we  in  N_MASTERS x field width, packed  master requests
  m_dat_r/m_ack/m_err  out  N_MASTERS x field width  master responses
  s_adr/s_dat_w/s_sel/s_cti/s_bte/s_cyc/s_stb/s_we  out  N_SLAVES x field width  slave requests
  s_dat_r/s_ack/s_err  in  N_SLAVES x field width  slave responses
  gnt  out  N_MASTERS  one-hot current grant, 0 when idle
  timeout  out  1  single-cycle pulse on watchdog expiry
REQ-008 Master/slave index i SHALL occupy slice [i*W +: W] of every packed port.

Function
REQ-009 Shared-bus topology: at most one master SHALL own the bus at any time.
REQ-010 FSM states IDLE, BUSY, ERR_RESP SHALL be implemented.
REQ-011 IDLE: when any m_cyc[i]&m_stb[i], grant SHALL go to the first requester at or after (last_grant+1) mod N_MASTERS; gnt registered, BUSY entered next cycle.
REQ-012 last_grant SHALL update on every grant; reset value N_MASTERS-1, so master 0 wins the first contention.
REQ-013 BUSY: granted master's adr decoded combinationally; lowest-index slave with base<=adr<=limit SHALL be selected.
REQ-014 Selected slave SHALL receive all request fields of the granted master; all other slaves s_cyc=s_stb=0.
REQ-015 Selected slave's dat_r/ack/err SHALL route to the granted master only, zero latency; non-granted masters see ack=err=0, dat_r=0.
REQ-016 Unmapped address with m_stb high in BUSY SHALL move to ERR_RESP; ERR_RESP asserts m_err to the granted master for exactly one cycle, no slave strobed, then returns to BUSY.
REQ-017 Grant SHALL be held across beats while the granted m_cyc stays high; m_cyc low in BUSY SHALL return to IDLE next cycle (minimum one idle cycle between grants).
REQ-018 Watchdog: counter SHALL increment each BUSY cycle with m_stb high and no ack/err; clear on ack, err, m_stb low or state change.
REQ-019 Counter reaching TIMEOUT_CYCLES SHALL enter ERR_RESP, pulse timeout, force s_cyc/s_stb low for that cycle.
REQ-020 Simultaneous slave ack and err SHALL forward both unmodified; ack coincident with watchdog expiry SHALL take priority (no timeout).
REQ-021 Requests from non-granted masters SHALL be stalled (no ack/err) without loss.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), saturating, no wrap.

Reset
REQ-023 rstn low SHALL asynchronously force state IDLE, gnt=0, timeout=0, counter=0, last_grant=N_MASTERS-1.
REQ-024 During reset all outputs SHALL be 0, including mid-transfer; no in-flight ack forwarded after reset release.

Structure
REQ-025 Package wb_interconnect_pkg SHALL hold the FSM state enum and range-decode function.
REQ-026 Round-robin arbitration SHALL be a sub-module wb_rr_arbiter #(N) (req, last, gnt one-hot).

Verification
REQ-027 N=2, M=7: m0,m1 request same cycle after reset -> m0 granted; after m0 drops cyc, m1 granted; next contention -> m0.
REQ-028 m0 adr inside slave 3 range, write 0xDEADBEEF -> only s3 strobed, ack returned to m0 same cycle as s3 ack.
REQ-029 adr outside all ranges -> m_err one cycle, exactly 2 cycles after m_stb rise (grant + ERR_RESP), no s_stb.
REQ-030 TIMEOUT_CYCLES=4, slave never acks -> timeout pulse and m_err after 4 stalled cycles, s_stb low that cycle.
REQ-031 4-beat burst (cti=010) from m1 while m0 requests -> m0 stalled until m1 drops cyc, no beat lost.
REQ-032 rstn asserted mid-burst -> all outputs 0 same cycle; first request after release served normally.

Source files
------------

// File: rtl/wb_interconnect_pkg.sv
// ---------------------------------------------------------------------------
// wb_interconnect_pkg
// Shared definitions for the round-robin N x M Wishbone shared-bus
// interconnect: controller state encoding, fixed Wishbone sideband widths,
// and the address-window helpers used by the slave decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package wb_interconnect_pkg;

    // Registered-feedback Wishbone sideband widths.
    localparam int CTI_W  = 3;
    localparam int BTE_W  = 2;

    // Widest address the range helper compares; narrower buses zero-extend.
    localparam int MAX_AW = 64;

    // Bus controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // no owner, arbitrating
        ST_BUSY     = 2'd1,   // granted master routed to decoded slave
        ST_ERR_RESP = 2'd2    // one-cycle error reply to the owner
    } wb_state_e;

    // Width of an index able to name n distinct items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Inclusive window check: base <= adr <= limit.
    function automatic logic addr_in_range(
        input logic [MAX_AW-1:0] adr,
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] limit
    );
        return (adr >= base) && (adr <= limit);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// the previous winner and wraps, so every requester is served within N
// grants.
//   req     in   N       active requests
//   last    in   IW      index of the previous winner
//   gnt     out  N       one-hot winner (all zero when no request)
//   gnt_idx out  IW      binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_interconnect_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // NOTE: every output gets a default before the search so that no path
    // through this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        int  cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                gnt_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect_rr_nxm.sv
// ---------------------------------------------------------------------------
// wb_interconnect_rr_nxm
// Shared-bus Wishbone interconnect: N_MASTERS masters compete round-robin
// for a single bus that is address-decoded onto N_SLAVES slaves. Unmapped
// accesses and stalled slaves (watchdog) are answered with a one-cycle
// error. Every packed port carries index i in slice [i*W +: W].
//
//   clk, rstn                          clock, asynchronous active-low reset
//   m_adr/m_dat_w/m_sel/m_cti/m_bte    master request fields   (in)
//   m_cyc/m_stb/m_we                   master request controls (in)
//   m_dat_r/m_ack/m_err                master responses        (out)
//   s_adr/s_dat_w/s_sel/s_cti/s_bte    slave request fields    (out)
//   s_cyc/s_stb/s_we                   slave request controls  (out)
//   s_dat_r/s_ack/s_err                slave responses         (in)
//   gnt                                one-hot bus owner, 0 when idle
//   timeout                            one-cycle pulse on watchdog expiry
//
// ADDR_RANGES holds one {base,limit} pair per slave, slave 0 in the MSBs and
// base above limit within each pair; both bounds are inclusive and the
// lowest-index matching slave wins.
// ---------------------------------------------------------------------------
module wb_interconnect_rr_nxm
    import wb_interconnect_pkg::*;
#(
    parameter int N_MASTERS     = 2,
    parameter int N_SLAVES      = 7,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    // master side
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]       m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]       m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_sel,
    input  logic [N_MASTERS*CTI_W-1:0]               m_cti,
    input  logic [N_MASTERS*BTE_W-1:0]               m_bte,
    input  logic [N_MASTERS-1:0]                     m_cyc,
    input  logic [N_MASTERS-1:0]                     m_stb,
    input  logic [N_MASTERS-1:0]                     m_we,
    output logic [N_MASTERS*WB_DATA_WIDTH-1:0]       m_dat_r,
    output logic [N_MASTERS-1:0]                     m_ack,
    output logic [N_MASTERS-1:0]                     m_err,
    // slave side
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]        s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]        s_dat_w,
    output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]    s_sel,
    output logic [N_SLAVES*CTI_W-1:0]                s_cti,
    output logic [N_SLAVES*BTE_W-1:0]                s_bte,
    output logic [N_SLAVES-1:0]                      s_cyc,
    output logic [N_SLAVES-1:0]                      s_stb,
    output logic [N_SLAVES-1:0]                      s_we,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]        s_dat_r,
    input  logic [N_SLAVES-1:0]                      s_ack,
    input  logic [N_SLAVES-1:0]                      s_err,
    // status
    output logic [N_MASTERS-1:0]                     gnt,
    output logic                                     timeout
);

    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;
    localparam int SW    = WB_DATA_WIDTH / 8;
    localparam int MIW   = idx_width(N_MASTERS);
    localparam int SIW   = idx_width(N_SLAVES);

    // A zero TIMEOUT_CYCLES disables the watchdog; keep the counter one bit
    // wide in that case so the logic still elaborates.
    localparam bit             WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam int             CNT_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wb_state_e             state_q, state_d;
    logic [N_MASTERS-1:0]  gnt_q, gnt_d;
    logic [MIW-1:0]        last_q, last_d;   // also the current owner index
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Owner request fields (last_q names the owner while not idle)
    // ------------------------------------------------------------------
    logic [AW-1:0]    g_adr;
    logic [DW-1:0]    g_dat_w;
    logic [SW-1:0]    g_sel;
    logic [CTI_W-1:0] g_cti;
    logic [BTE_W-1:0] g_bte;
    logic             g_cyc, g_stb, g_we;

    assign g_adr   = m_adr  [int'(last_q)*AW    +: AW];
    assign g_dat_w = m_dat_w[int'(last_q)*DW    +: DW];
    assign g_sel   = m_sel  [int'(last_q)*SW    +: SW];
    assign g_cti   = m_cti  [int'(last_q)*CTI_W +: CTI_W];
    assign g_bte   = m_bte  [int'(last_q)*BTE_W +: BTE_W];
    assign g_cyc   = m_cyc  [last_q];
    assign g_stb   = m_stb  [last_q];
    assign g_we    = m_we   [last_q];

    // ------------------------------------------------------------------
    // Address decode: lowest-index slave whose window contains g_adr
    // ------------------------------------------------------------------
    logic           hit;
    logic [SIW-1:0] sel_idx;
    logic           sel_ack, sel_err;

    always_comb begin
        logic [AW-1:0] base, limit;
        hit     = 1'b0;
        sel_idx = '0;
        base    = '0;
        limit   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            base  = ADDR_RANGES[((N_SLAVES-1-i)*2+1)*AW +: AW];
            limit = ADDR_RANGES[((N_SLAVES-1-i)*2)*AW   +: AW];
            if (!hit && addr_in_range(MAX_AW'(g_adr), MAX_AW'(base), MAX_AW'(limit))) begin
                hit     = 1'b1;
                sel_idx = SIW'(i);
            end
        end
    end

    assign sel_ack = s_ack[sel_idx];
    assign sel_err = s_err[sel_idx];

    // ------------------------------------------------------------------
    // Arbitration (only consulted in IDLE)
    // ------------------------------------------------------------------
    logic [N_MASTERS-1:0] arb_req, arb_gnt;
    logic [MIW-1:0]       arb_idx;

    assign arb_req = m_cyc & m_stb;

    wb_rr_arbiter #(
        .N       (N_MASTERS)
    ) u_arb (
        .req     (arb_req),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // ------------------------------------------------------------------
    // Watchdog: a stall is a live, mapped strobe the slave leaves unanswered
    // ------------------------------------------------------------------
    logic             stall;
    logic [CNT_W-1:0] cnt_inc;

    assign stall   = (state_q == ST_BUSY) && g_cyc && g_stb && hit && !sel_ack && !sel_err;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Controller: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = arb_gnt;
                    last_d  = arb_idx;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    // Owner released the bus; always pass through IDLE.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (g_stb && !hit) begin
                    state_d = ST_ERR_RESP;
                end else if (stall) begin
                    // The expiring stall is the last one counted; the error
                    // reply then occupies the following cycle.
                    if (WD_EN && (cnt_inc == TO_VAL)) begin
                        state_d   = ST_ERR_RESP;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_ERR_RESP: begin
                state_d = ST_BUSY;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the values
    // that existed before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            last_q    <= MIW'(N_MASTERS - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign timeout = timeout_q;

    // ------------------------------------------------------------------
    // Data path routing. Everything is gated by state, so reset (IDLE)
    // silences all outputs immediately, including mid-transfer.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_bte   = '0;
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        m_dat_r = '0;
        m_ack   = '0;
        m_err   = '0;
        if ((state_q == ST_BUSY) && g_cyc && hit) begin
            s_adr  [int'(sel_idx)*AW    +: AW]    = g_adr;
            s_dat_w[int'(sel_idx)*DW    +: DW]    = g_dat_w;
            s_sel  [int'(sel_idx)*SW    +: SW]    = g_sel;
            s_cti  [int'(sel_idx)*CTI_W +: CTI_W] = g_cti;
            s_bte  [int'(sel_idx)*BTE_W +: BTE_W] = g_bte;
            s_cyc  [sel_idx]                      = 1'b1;
            s_stb  [sel_idx]                      = g_stb;
            s_we   [sel_idx]                      = g_we;
            // Responses pass through unmodified, ack and err alike.
            m_dat_r[int'(last_q)*DW +: DW]        = s_dat_r[int'(sel_idx)*DW +: DW];
            m_ack  [last_q]                       = sel_ack;
            m_err  [last_q]                       = sel_err;
        end else if (state_q == ST_ERR_RESP) begin
            m_err[last_q] = 1'b1;
        end
    end

endmodule
